// File: rtl/test_rand_delay_source.sv
// -----------------------------------------------------------------------------
// test_rand_delay_source
//
// Test source that streams back a list of messages over a val/rdy
// handshake. Messages are appended while idle. After start, a
// pseudo-random number of idle cycles in 0..max_delay comes before
// each message. The random numbers come from a 32-bit Galois LFSR.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   reset      : synchronous, active-high reset
//   max_delay  : inclusive upper bound on idle cycles before each message
//   load_val   : append load_msg to the store (honoured only in IDLE, not full)
//   load_msg   : message to append
//   load_full  : store holds p_num_msgs entries
//   start      : begin streaming (sampled only in IDLE)
//   val        : output message valid
//   rdy        : downstream ready
//   msg        : output message
//   done       : every loaded message has been accepted downstream
// -----------------------------------------------------------------------------
module test_rand_delay_source #(
    parameter int p_msg_nbits = 1,
    parameter int p_num_msgs  = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            max_delay,
    input  logic                   load_val,
    input  logic [p_msg_nbits-1:0] load_msg,
    output logic                   load_full,
    input  logic                   start,
    output logic                   val,
    input  logic                   rdy,
    output logic [p_msg_nbits-1:0] msg,
    output logic                   done
);

    localparam int c_cnt_nbits  = $clog2(p_num_msgs) + 1;
    localparam int c_addr_nbits = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

    localparam logic [c_cnt_nbits-1:0]  c_cnt_one   = c_cnt_nbits'(1);
    localparam logic [c_cnt_nbits-1:0]  c_cnt_full  = c_cnt_nbits'(p_num_msgs);
    localparam logic [c_addr_nbits-1:0] c_last_addr = c_addr_nbits'(p_num_msgs - 1);
    localparam logic [31:0]             c_lfsr_mask = 32'h8020_0003;
    localparam logic [31:0]             c_lfsr_seed = 32'h0000_ACE1;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SEND,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [p_msg_nbits-1:0] mem [p_num_msgs];
    logic [c_cnt_nbits-1:0] wr_cnt;
    logic [c_cnt_nbits-1:0] rd_idx;
    logic [31:0]            lfsr;
    logic [31:0]            lfsr_nxt;
    // The counter shares the 33-bit width of the delay result.
    logic [32:0]            dly_cnt;
    logic [32:0]            mod_den;
    logic [32:0]            draw_dly;
    logic                   draw;
    logic                   load_acc;
    logic                   xfer;
    logic [c_addr_nbits-1:0] wr_addr;
    logic [c_addr_nbits-1:0] rd_addr;

    // ---------------------------------------------------------------------
    // Datapath helpers
    // ---------------------------------------------------------------------
    assign load_full = (wr_cnt == c_cnt_full);
    assign load_acc  = (state == IDLE) && load_val && !load_full;
    assign xfer      = (state == SEND) && rdy;
    assign wr_addr   = wr_cnt[c_addr_nbits-1:0];

    // After the last message rd_idx equals wr_cnt and can reach
    // p_num_msgs, so clamp it to keep msg well defined.
    assign rd_addr = (rd_idx >= c_cnt_full) ? c_last_addr : rd_idx[c_addr_nbits-1:0];

    // The Galois LFSR shifts right and XORs the mask in when bit 0 falls out.
    assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? c_lfsr_mask : 32'd0);

    // The modulus is computed in 33 bits so max_delay = 32'hFFFFFFFF still
    // gives a nonzero divisor.
    assign mod_den  = {1'b0, max_delay} + 33'd1;
    assign draw_dly = (max_delay == 32'd0) ? 33'd0 : ({1'b0, lfsr} % mod_den);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic (also decides when a delay is drawn)
    // ---------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        draw      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (wr_cnt == '0) begin
                        state_nxt = DONE;
                    end else begin
                        draw      = 1'b1;
                        state_nxt = (draw_dly == 33'd0) ? SEND : DELAY;
                    end
                end
            end
            DELAY: begin
                if (dly_cnt <= 33'd1) state_nxt = SEND;
            end
            SEND: begin
                if (rdy) begin
                    if ((rd_idx + c_cnt_one) == wr_cnt) begin
                        state_nxt = DONE;
                    end else begin
                        draw      = 1'b1;
                        state_nxt = (draw_dly == 33'd0) ? SEND : DELAY;
                    end
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (registered state only, so rdy has no path to val/msg)
    // ---------------------------------------------------------------------
    always_comb begin
        val  = (state == SEND);
        done = (state == DONE);
        msg  = mem[rd_addr];
    end

    // ---------------------------------------------------------------------
    // Counters and LFSR
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt  <= '0;
            rd_idx  <= '0;
            dly_cnt <= '0;
            lfsr    <= c_lfsr_seed;
        end else begin
            if (load_acc) wr_cnt <= wr_cnt + c_cnt_one;
            if (xfer)     rd_idx <= rd_idx + c_cnt_one;
            if (draw) begin
                lfsr    <= lfsr_nxt;
                dly_cnt <= draw_dly;
            end else if (state == DELAY) begin
                dly_cnt <= dly_cnt - 33'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Message store
    // ---------------------------------------------------------------------
    // NOTE: the store has no reset. Clearing wr_cnt makes old entries
    // unreachable, and leaving the reset off lets the array map onto RAM.
    always_ff @(posedge clk) begin
        if (load_acc) mem[wr_addr] <= load_msg;
    end

endmodule

// File: tb/tb_test_rand_delay_source.sv
// -----------------------------------------------------------------------------
// tb_test_rand_delay_source
//
// Directed bench for test_rand_delay_source (8-bit messages, depth 16).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// A transfer is taken when val and rdy are both high at a sample point.
// Expected delays come from an independent LFSR model and from a few
// values worked out by hand.
// -----------------------------------------------------------------------------
module tb_test_rand_delay_source;

    localparam int          c_w    = 8;
    localparam int          c_n    = 16;
    localparam logic [31:0] c_seed = 32'h0000_ACE1;
    localparam logic [31:0] c_mask = 32'h8020_0003;

    logic            clk;
    logic            reset;
    logic [31:0]     max_delay;
    logic            load_val;
    logic [c_w-1:0]  load_msg;
    logic            load_full;
    logic            start;
    logic            val;
    logic            rdy;
    logic [c_w-1:0]  msg;
    logic            done;

    test_rand_delay_source #(
        .p_msg_nbits (c_w),
        .p_num_msgs  (c_n)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .max_delay (max_delay),
        .load_val  (load_val),
        .load_msg  (load_msg),
        .load_full (load_full),
        .start     (start),
        .val       (val),
        .rdy       (rdy),
        .msg       (msg),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             total = 0;
    int             bad   = 0;
    logic [31:0]    lfsr_m;
    logic [c_w-1:0] got_msg[$];
    int             got_gap[$];
    logic [c_w-1:0] exp_q[$];
    int             last_xfer;
    int             done_at;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        check("rst_val", val, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_full", load_full, 1'b0);
        reset  = 1'b0;
        lfsr_m = c_seed;
    endtask

    task automatic load(input logic [c_w-1:0] v);
        load_val = 1'b1;
        load_msg = v;
        step();
        load_val = 1'b0;
    endtask

    // Reference delay draw: the value before the shift, modulo max_delay+1.
    task automatic model_draw(output logic [32:0] d);
        d      = (max_delay == 32'd0) ? 33'd0 : ({1'b0, lfsr_m} % ({1'b0, max_delay} + 33'd1));
        lfsr_m = {1'b0, lfsr_m[31:1]} ^ (lfsr_m[0] ? c_mask : 32'd0);
    endtask

    // Pulse start and then collect transfers until done. Arguments:
    //   stall     : number of cycles rdy is held low at the first val
    //   hold_exp  : message that must stay on msg during that stall
    //   junk      : number of load_val=1 cycles to drive right after start
    //   budget    : cycle limit on the wait for done
    task automatic run_stream(input int stall, input logic [c_w-1:0] hold_exp,
                              input int junk, input int budget);
        int idle;
        int stalled;
        idle      = 0;
        stalled   = 0;
        last_xfer = -1;
        done_at   = -1;
        got_msg.delete();
        got_gap.delete();
        rdy   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done) begin
                done_at = cyc;
                break;
            end
            load_val = (cyc < junk);
            load_msg = 8'h99;
            if (val) begin
                if (stalled < stall) begin
                    rdy = 1'b0;
                    stalled++;
                    check("hold_msg", msg, hold_exp);
                end else begin
                    rdy = 1'b1;
                    got_msg.push_back(msg);
                    got_gap.push_back(idle);
                    idle      = 0;
                    last_xfer = cyc;
                end
            end else begin
                idle++;
            end
            step();
        end
        load_val = 1'b0;
        rdy      = 1'b1;
        check("stream_done", (done_at >= 0), 1'b1);
        check("stall_seen", stalled, stall);
    endtask

    task automatic verify_msgs();
        check("msg_count", got_msg.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_msg.size(); i++)
            check($sformatf("msg%0d", i), got_msg[i], exp_q[i]);
    endtask

    task automatic verify_gaps();
        logic [32:0] d;
        lfsr_m = c_seed;
        for (int i = 0; i < got_gap.size(); i++) begin
            model_draw(d);
            check($sformatf("gap%0d", i), got_gap[i], d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        load_val  = 1'b0;
        load_msg  = '0;
        rdy       = 1'b1;
        max_delay = 32'd0;
        lfsr_m    = c_seed;
        step();

        // Zero delay: three back-to-back transfers, then done one cycle later.
        do_reset();
        max_delay = 32'd0;
        load(8'h11); load(8'h22); load(8'h33);
        check("zd_full", load_full, 1'b0);
        exp_q = '{8'h11, 8'h22, 8'h33};
        run_stream(0, 8'h00, 0, 100);
        verify_msgs();
        verify_gaps();
        for (int i = 0; i < got_gap.size(); i++) check($sformatf("zd_gap%0d", i), got_gap[i], 0);
        check("zd_done_lat", done_at - last_xfer, 1);
        check("zd_val_done", val, 1'b0);

        // Backpressure: 11 held for 4 stalled cycles plus the accepting cycle.
        do_reset();
        load(8'h11); load(8'h22); load(8'h33);
        exp_q = '{8'h11, 8'h22, 8'h33};
        run_stream(4, 8'h11, 0, 100);
        verify_msgs();
        for (int i = 0; i < got_gap.size(); i++) check($sformatf("bp_gap%0d", i), got_gap[i], 0);

        // Random delay with max_delay=3 over 16 messages.
        do_reset();
        max_delay = 32'd3;
        exp_q.delete();
        for (int i = 0; i < c_n; i++) begin
            load(8'(8'h40 + i));
            exp_q.push_back(8'(8'h40 + i));
        end
        run_stream(0, 8'h00, 0, 300);
        verify_msgs();
        verify_gaps();
        // Worked by hand: ACE1 % 4 = 1, then 80205673 % 4 = 3.
        if (got_gap.size() >= 2) begin
            check("rd_hand_gap0", got_gap[0], 1);
            check("rd_hand_gap1", got_gap[1], 3);
        end
        for (int i = 0; i < got_gap.size(); i++) check($sformatf("rd_range%0d", i), (got_gap[i] <= 3), 1'b1);

        // Start with nothing loaded: done, val never high, DONE is terminal.
        do_reset();
        max_delay = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("empty_val0", val, 1'b0);
        step();
        check("empty_done", done, 1'b1);
        check("empty_val1", val, 1'b0);
        start    = 1'b1;
        load_val = 1'b1;
        load_msg = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("term_done%0d", i), done, 1'b1);
            check($sformatf("term_val%0d", i), val, 1'b0);
        end
        start    = 1'b0;
        load_val = 1'b0;
        check("term_full", load_full, 1'b0);

        // Overfill: full after the 16th load, and the 17th entry is never sent.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < c_n + 1; i++) begin
            load(8'(i + 1));
            check($sformatf("full_after%0d", i + 1), load_full, (i + 1 >= c_n));
            if (i < c_n) exp_q.push_back(8'(i + 1));
        end
        run_stream(0, 8'h00, 0, 100);
        verify_msgs();

        // Reset while message 2 of 5 is on the output.
        do_reset();
        for (int i = 0; i < 5; i++) load(8'(8'h51 + i));
        rdy   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("mr_val_m1", val, 1'b1);
        check("mr_msg_m1", msg, 8'h51);
        step();
        check("mr_val_m2", val, 1'b1);
        check("mr_msg_m2", msg, 8'h52);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_val", val, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_full", load_full, 1'b0);
        lfsr_m = c_seed;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mr_quiet%0d", i), val, 1'b0);
        end
        load(8'hAA);
        exp_q = '{8'hAA};
        run_stream(0, 8'h00, 0, 100);
        verify_msgs();

        // Loads during DELAY are ignored. The first gap is ACE1 % 101 = 19.
        do_reset();
        max_delay = 32'd100;
        load(8'h11); load(8'h22); load(8'h33);
        exp_q = '{8'h11, 8'h22, 8'h33};
        run_stream(0, 8'h00, 5, 1000);
        verify_msgs();
        verify_gaps();
        if (got_gap.size() >= 1) check("ld_hand_gap0", got_gap[0], 19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
